// File: rtl/cpu6_bus_responder.sv
// CPU6 memory-bus slave: synchronous RAM plus a MUX-style console port
// (status/data registers, TX FIFO with valid/ready egress, single-byte RX holding register).
module cpu6_bus_responder #(
  parameter int          RAM_ADDR_BITS = 12,
  parameter logic [15:0] MUX_BASE      = 16'hF200,
  parameter int          TX_DEPTH      = 4,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  dataOutBus,
  input  logic        writeEnBus,
  output logic [7:0]  dataInBus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_irq
);

  localparam int          RAM_WORDS = 1 << RAM_ADDR_BITS;
  localparam int          PTR_W     = $clog2(TX_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [15:0] MUX_DATA  = MUX_BASE + 16'd1;

  logic [7:0]       ram [0:RAM_WORDS-1];
  logic [7:0]       fifo [0:TX_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             rx_full, rx_overrun;
  logic [7:0]       rx_hold;

  logic sel_ram, sel_stat, sel_data;
  logic tx_not_full, push, pop, stat_clr;
  logic [7:0] stat;

  assign sel_ram  = (addressBus[15:RAM_ADDR_BITS] == '0);
  assign sel_stat = (addressBus == MUX_BASE);
  assign sel_data = (addressBus == MUX_DATA);

  assign tx_not_full = (count != CNT_W'(TX_DEPTH));
  assign tx_valid    = (count != '0);
  assign tx_data     = fifo[rd_ptr];
  // Push is judged on pre-edge count, so a full FIFO drops the byte even during a pop.
  assign push        = writeEnBus & sel_data & tx_not_full;
  assign pop         = tx_valid & tx_ready;
  assign stat_clr    = writeEnBus & sel_stat;
  assign stat        = {5'b0, rx_overrun, tx_not_full, rx_full};
  assign rx_irq      = rx_full;

  // Read-first: the nonblocking RAM write lands after this edge's load.
  always_ff @(posedge clock) begin
    if (reset)         dataInBus <= 8'h00;
    else if (sel_ram)  dataInBus <= ram[addressBus[RAM_ADDR_BITS-1:0]];
    else if (sel_stat) dataInBus <= stat;
    else if (sel_data) dataInBus <= rx_hold;
    else               dataInBus <= UNMAPPED_DATA;
  end

  always_ff @(posedge clock) begin
    if (!reset && writeEnBus && sel_ram)
      ram[addressBus[RAM_ADDR_BITS-1:0]] <= dataOutBus;
  end

  always_ff @(posedge clock) begin
    if (!reset && push)
      fifo[wr_ptr] <= dataOutBus;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A status write clears first, so a coincident rx_valid latches into an empty holder.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
      rx_hold    <= 8'h00;
    end else begin
      if (stat_clr) begin
        rx_full    <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (rx_valid) begin
        if (!rx_full || stat_clr) begin
          rx_hold <= rx_data;
          rx_full <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
